// File: rtl/hci_core_wrr_scheduler_pkg.sv
// Shared types and defaults for the hci_core weighted round-robin scheduler.
package hci_package;
  localparam int HCI_WRR_WEIGHT_W       = 4;
  localparam int HCI_WRR_STARVE_DEFAULT = 16;
  typedef logic [HCI_WRR_WEIGHT_W-1:0] wrr_weight_t;
endpackage

// File: rtl/hci_core_wrr_id_fifo.sv
// In-order queue of issuing-requester IDs; head is visible combinationally.
// Push is ignored when full and pop is ignored when empty.
module hci_core_wrr_id_fifo #(
  parameter int  W     = 2,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/hci_core_wrr_scheduler.sv
// Weighted round-robin owner of one hci_core channel: zero-latency grant, per-owner burst budget,
// starvation preemption, responses steered back in issue order; new requests stall while the ID queue is full.
module hci_core_wrr_scheduler
  import hci_package::*;
#(
  parameter int  NB_REQ       = 4,
  parameter int  WEIGHT_W     = HCI_WRR_WEIGHT_W,
  parameter int  MAX_OUTST    = 4,
  parameter int  STARVE_LIMIT = HCI_WRR_STARVE_DEFAULT,
  localparam int IDW          = $clog2(NB_REQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic [NB_REQ*WEIGHT_W-1:0] cfg_weight_i,
  input  logic [NB_REQ-1:0]          req_i,
  output logic [NB_REQ-1:0]          gnt_o,
  output logic [IDW-1:0]             sel_o,
  output logic                       out_req_o,
  input  logic                       out_gnt_i,
  input  logic                       out_r_valid_i,
  output logic [NB_REQ-1:0]          r_valid_o,
  output logic                       busy_o,
  output logic                       err_o
);
  localparam int WAITW = $clog2(STARVE_LIMIT + 1);

  logic [IDW-1:0]      owner_q;
  logic [WEIGHT_W-1:0] budget_q;
  logic [WAITW-1:0]    wait_q [NB_REQ];
  logic                err_q;
  logic [IDW-1:0]      winner, head;
  logic [WEIGHT_W-1:0] weight, reload;
  logic                found, full, empty, hs, pop;
  int                  cand;

  assign out_req_o = (|req_i) && !full;
  assign hs        = out_req_o && out_gnt_i;
  assign pop       = out_r_valid_i && !empty;
  assign sel_o     = winner;
  assign busy_o    = !empty;
  assign err_o     = err_q;
  assign gnt_o     = hs  ? (NB_REQ'(1) << winner) : '0;
  assign r_valid_o = pop ? (NB_REQ'(1) << head)   : '0;

  // Priority: starved requester, then current owner with budget left, then rotate past owner.
  always_comb begin
    winner = owner_q;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (!found && req_i[k] && (wait_q[k] >= WAITW'(STARVE_LIMIT))) begin
        winner = IDW'(k);
        found  = 1'b1;
      end
    end
    if (!found && req_i[owner_q] && (budget_q != '0)) found = 1'b1;
    for (int i = 1; i <= NB_REQ; i++) begin
      cand = (int'(owner_q) + i) % NB_REQ;
      if (!found && req_i[IDW'(cand)]) begin
        winner = IDW'(cand);
        found  = 1'b1;
      end
    end
  end

  // A zero weight still grants one beat, so the reload never underflows.
  assign weight = cfg_weight_i[int'(winner)*WEIGHT_W +: WEIGHT_W];
  assign reload = (weight == '0) ? '0 : weight - 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q  <= '0;
      budget_q <= '0;
      err_q    <= 1'b0;
      for (int k = 0; k < NB_REQ; k++) wait_q[k] <= '0;
    end else if (clear_i) begin
      owner_q  <= '0;
      budget_q <= '0;
      err_q    <= 1'b0;
      for (int k = 0; k < NB_REQ; k++) wait_q[k] <= '0;
    end else begin
      if (out_r_valid_i && empty) err_q <= 1'b1;
      if (hs) begin
        if ((winner == owner_q) && (budget_q != '0)) begin
          budget_q <= budget_q - 1'b1;
        end else begin
          owner_q  <= winner;
          budget_q <= reload;
        end
      end
      for (int k = 0; k < NB_REQ; k++) begin
        if (!req_i[k] || (hs && (winner == IDW'(k)))) wait_q[k] <= '0;
        else if (wait_q[k] < WAITW'(STARVE_LIMIT))    wait_q[k] <= wait_q[k] + 1'b1;
      end
    end
  end

  hci_core_wrr_id_fifo #(
    .W     (IDW),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (clear_i),
    .push      (hs),
    .push_data (winner),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );
endmodule

// File: tb/tb_hci_core_wrr_scheduler.sv
// Randomized and directed bench for hci_core_wrr_scheduler against a queue-based reference model.
module tb_hci_core_wrr_scheduler;
  import hci_package::*;

  localparam int N     = 4;
  localparam int LIMIT = 16;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clear = 1'b0;
  wrr_weight_t    wts [N];
  logic [N*4-1:0] cfg_weight;
  logic [N-1:0]   req = '0;
  logic           out_gnt = 1'b0, out_r_valid = 1'b0;
  logic [N-1:0]   gnt, r_valid;
  logic [1:0]     sel;
  logic           out_req, busy, err;
  logic [N-1:0]   s_gnt, s_rv;
  logic [1:0]     s_sel;
  logic           s_oreq, s_busy, s_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] obs_gnt, obs_rv, obs_sgnt;
  logic         obs_oreq, obs_err;

  // Reference model state
  int m_owner, m_budget;
  int m_wait [N];
  int m_q [$];
  bit m_err;

  always #5 clk = ~clk;
  assign cfg_weight = {wts[3], wts[2], wts[1], wts[0]};

  hci_core_wrr_scheduler #(.NB_REQ(N), .WEIGHT_W(4), .MAX_OUTST(DEPTH), .STARVE_LIMIT(LIMIT)) u_dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .cfg_weight_i(cfg_weight), .req_i(req),
    .gnt_o(gnt), .sel_o(sel), .out_req_o(out_req), .out_gnt_i(out_gnt),
    .out_r_valid_i(out_r_valid), .r_valid_o(r_valid), .busy_o(busy), .err_o(err)
  );

  hci_core_wrr_scheduler #(.NB_REQ(N), .WEIGHT_W(4), .MAX_OUTST(DEPTH), .STARVE_LIMIT(4)) u_starve (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .cfg_weight_i(cfg_weight), .req_i(req),
    .gnt_o(s_gnt), .sel_o(s_sel), .out_req_o(s_oreq), .out_gnt_i(out_gnt),
    .out_r_valid_i(out_r_valid), .r_valid_o(s_rv), .busy_o(s_busy), .err_o(s_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner  = 0;
    m_budget = 0;
    foreach (m_wait[k]) m_wait[k] = 0;
    m_q.delete();
    m_err = 1'b0;
  endfunction

  function automatic int model_winner(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[k] && m_wait[k] >= LIMIT) return k;
    if (r[m_owner] && m_budget > 0) return m_owner;
    for (int i = 1; i <= N; i++) if (r[(m_owner + i) % N]) return (m_owner + i) % N;
    return m_owner;
  endfunction

  // Called at a falling edge; drives one cycle, checks outputs mid-cycle, advances the model.
  task automatic cycle(input logic [N-1:0] r, input logic g, input logic v, input logic c);
    int   win;
    logic full_e, oreq_e, hs_e;
    req = r; out_gnt = g; out_r_valid = v; clear = c;
    #2;
    win    = model_winner(r);
    full_e = (m_q.size() == DEPTH);
    oreq_e = (r != '0) && !full_e;
    hs_e   = oreq_e && g;
    obs_gnt = gnt; obs_rv = r_valid; obs_oreq = out_req; obs_err = err; obs_sgnt = s_gnt;
    check("gnt", gnt, hs_e ? (1 << win) : 0);
    check("sel", sel, win);
    check("out_req", out_req, oreq_e);
    check("r_valid", r_valid, (v && m_q.size() > 0) ? (1 << m_q[0]) : 0);
    check("busy", busy, m_q.size() > 0);
    check("err", err, m_err);
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      if (v) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (hs_e) m_q.push_back(win);
      for (int k = 0; k < N; k++) begin
        if (!r[k] || (hs_e && win == k)) m_wait[k] = 0;
        else if (m_wait[k] < LIMIT) m_wait[k]++;
      end
      if (hs_e) begin
        if (win == m_owner && m_budget > 0) m_budget--;
        else begin
          m_owner  = win;
          m_budget = (wts[win] == 0) ? 0 : int'(wts[win]) - 1;
        end
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge.
  task automatic do_reset();
    req = '0; out_gnt = 1'b0; out_r_valid = 1'b0; clear = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_busy", busy, 0);
    check("rst_sel", sel, 0);
    check("rst_gnt", gnt, 0);
    check("rst_out_req", out_req, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seq1 [5];
    int seq3 [9];
    logic [N-1:0] r;
    logic g, v, c;
    int cnt, idx;
    seq1 = '{1, 2, 3, 0, 1};
    seq3 = '{1, 2, 3, 0, 0, 0, 1, 2, 3};
    wts = '{default: 1};
    @(negedge clk);
    do_reset();

    // Equal weights: plain rotation, responses one cycle behind
    cycle('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'hF, 1'b1, i > 0, 1'b0);
      check("rr_equal_seq", obs_gnt, 1 << seq1[i]);
    end

    // Weight 3 on requester 0 gives it three-beat bursts
    wts = '{3, 1, 1, 1};
    wts[0] = 3; wts[1] = 1; wts[2] = 1; wts[3] = 1;
    cycle('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle(4'hF, 1'b1, i > 0, 1'b0);
      check("rr_weighted_seq", obs_gnt, 1 << seq3[i]);
    end

    // ID queue fill: four grants then stall; one response frees one slot
    cycle('0, 1'b0, 1'b1, 1'b1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(4'h1, 1'b1, 1'b0, 1'b0);
      cnt += int'(obs_gnt[0]);
    end
    check("fill_grants", cnt, 4);
    check("full_blocks_req", obs_oreq, 0);
    cycle(4'h1, 1'b1, 1'b1, 1'b0);
    check("pop_no_bypass", obs_oreq, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(4'h1, 1'b1, 1'b0, 1'b0);
      cnt += int'(obs_gnt[0]);
    end
    check("reopen_one", cnt, 1);

    // Response with empty queue: sticky error, cleared by clear
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1, 1'b0);
    check("empty_rv_dropped", obs_rv, 0);
    for (int i = 0; i < 3; i++) begin
      cycle('0, 1'b0, 1'b0, 1'b0);
      check("err_sticky", obs_err, 1);
    end
    cycle('0, 1'b0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0, 1'b0);
    check("err_cleared", obs_err, 0);

    // Starvation on the limit-4 instance: requester 2 preempts on its 5th waiting cycle
    wts[0] = 15;
    cycle(4'h1, 1'b1, 1'b0, 1'b0);
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(4'h5, 1'b1, 1'b1, 1'b0);
      if (idx < 0 && obs_sgnt[2]) idx = i;
    end
    check("starve_cycle", idx, 4);

    // Reset with three outstanding, then a late response and the first grant after reset
    wts = '{default: 1};
    cycle('0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'hF, 1'b1, 1'b0, 1'b0);
    do_reset();
    cycle('0, 1'b0, 1'b1, 1'b0);
    cycle(4'hF, 1'b1, 1'b0, 1'b0);
    check("post_rst_gnt", obs_gnt, 4'b0010);
    check("late_rsp_err", obs_err, 1);

    // Random traffic: light requests first, then dense requests to provoke starvation
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0)
        for (int k = 0; k < N; k++) wts[k] = wrr_weight_t'($urandom_range(0, 15));
      for (int k = 0; k < N; k++)
        r[k] = (i < 1000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) != 0);
      g = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle(r, g, v, c);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
